hilo_mdu: RTL
=============

# hilo_mdu

Parametrised iterative multiply/divide unit with built-in HI/LO registers. It replaces the single-shot multiply/divide path of the 32-bit MIPS pipeline. It adds configurable width, multiply-accumulate/subtract modes, cancellation on pipeline flush, and an explicit busy/done handshake that the hazard unit uses to stall the execute stage.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits. Legal values are even and ≥ 4.
- `ACCUM_EN`, default 1: enables the MADD/MSUB modes. When 0, MADD[U] and MSUB[U] behave as MULT[U].

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, **asynchronous, active-low**.
- `start` in 1: request a new operation. Accepted only when `busy`=0.
- `op` in 3: operation, sampled with `start`. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `a` in WIDTH: rs operand (multiplicand / dividend), sampled with `start`.
- `b` in WIDTH: rt operand (multiplier / divisor), sampled with `start`.
- `cancel` in 1: flush. Abort any operation; HI/LO are unchanged.
- `hi_we`, `lo_we` in 1: MTHI/MTLO write enables. Honoured only when `busy`=0.
- `hi_wdata`, `lo_wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: an operation is in flight; the execute stage stalls while it is high.
- `done` out 1: one-cycle pulse; HI/LO hold the new result during this cycle.
- `div_by_zero` out 1: one-cycle pulse coincident with `done` for DIV/DIVU with `b`=0.
- `hi`, `lo` out WIDTH: architectural HI/LO values, driven straight from the registers.

## Operation
- FSM states: IDLE → RUN → FINISH → IDLE.
- **IDLE**, `start`=1 and `cancel`=0:
  - Latch `op`.
  - For signed ops, latch |a| and |b| and record the result signs.
  - Clear the iteration counter and go to RUN.
- **RUN**: one radix-2 step per cycle, using the `mdu_iter_core` sub-module.
  - Multiply: shift-add into a 2·WIDTH-bit product.
  - Divide: restoring divide producing a WIDTH-bit quotient and remainder.
  - After WIDTH steps, go to FINISH.
- **FINISH**:
  - Apply sign correction.
  - MULT[U]: {HI,LO} ← product.
  - MADD[U]: {HI,LO} ← {HI,LO} + product.
  - MSUB[U]: {HI,LO} ← {HI,LO} − product.
  - All arithmetic is modulo 2^(2·WIDTH). Accumulation uses the HI/LO value present in FINISH.
  - DIV[U]: LO ← quotient, HI ← remainder.
  - Go to IDLE and pulse `done`.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - MIN / −1 gives LO=MIN and HI=0 (wraps, no trap).
- Divide by zero: the operation runs for the full latency. HI/LO are unchanged, and `div_by_zero` pulses with `done`.
- `hi_we`/`lo_we` while IDLE write HI/LO at the next edge. While `busy`=1 they are ignored; the controller must stall the MTHI/MTLO.
- `start` while `busy`=1 is ignored.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, HI=LO=0, counter=0, `busy`=0, `done`=0, `div_by_zero`=0. All outputs are registered.
- Let the start edge be T0:
  - `busy`=1 from T0 through edge T0+WIDTH+1.
  - HI/LO update at edge T0+WIDTH+1.
  - `done` and `div_by_zero` are high during the following cycle, with `busy`=0 in that same cycle.
  - Latency is WIDTH+1 cycles; 33 cycles for WIDTH=32.
- Back-to-back: `start` is accepted in the `done` cycle, giving a throughput of one op per WIDTH+2 cycles.
- `cancel` in any state: IDLE at the next edge, no `done`, HI/LO untouched.
  - `cancel` and `start` together: cancel wins and the start is dropped.
  - `cancel` in FINISH: the write is suppressed.
- `hi_we` together with `start` in IDLE: the write lands at T0, so a following MADD accumulates onto the written value.
- Reset asserted mid-operation: immediate return to reset values; there is no partial HI/LO write.

## Structure
- Package `mdu_pkg`:
  - `mdu_op_t` enum (8 encodings above).
  - `mdu_state_t` enum (IDLE, RUN, FINISH).
  - Helper predicates `is_div`, `is_signed`, `is_accum`, `is_sub`.
- One sub-module, `mdu_iter_core`:
  - Holds the shared WIDTH-step shift/add/subtract datapath and counter.
  - Parameter: WIDTH.
  - Ports: `init`, `step`, `mode_div`, operands; outputs `prod`, `quot`, `rem`, `last`.
- Top-level `hilo_mdu` holds the FSM, sign handling, accumulation, HI/LO registers and the write port.

## Test plan
- MULT a=0xFFFF_FFFE (−2), b=3 → after 33 cycles HI=0xFFFF_FFFF, LO=0xFFFF_FFFA, `done` pulses once. MULTU with the same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV a=−7, b=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIV 0x8000_0000 by −1 → LO=0x8000_0000, HI=0. DIVU 7/0 → HI/LO unchanged, `div_by_zero`=1 with `done`.
- `hi_we`=1 (0x1), `lo_we`=1 (0xFFFF_FFFF), then MADDU 1×1 → HI=2, LO=0. MSUB 1×1 from HI=LO=0 → HI=LO=0xFFFF_FFFF.
- Cancel at cycle 10 of a DIV → `busy` falls next cycle, no `done`, HI/LO keep prior values. A new `start` then completes normally.
- `start` and `hi_we` while busy → both ignored; the result matches an isolated op. `rst` low mid-RUN → HI=LO=0, `busy`=0 immediately.
- WIDTH=8 instance: MULT 0x80×0x80 → HI=0x40, LO=0x00, latency 9 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and op-decoding helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MADDU = 3'd5,
      OP_MSUB  = 3'd6,
      OP_MSUBU = 3'd7
   } mdu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } mdu_state_t;

   function automatic logic is_div(mdu_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Every odd encoding is the unsigned flavour.
   function automatic logic is_signed(mdu_op_t op);
      return ~op[0];
   endfunction

   function automatic logic is_accum(mdu_op_t op);
      return op[2];
   endfunction

   function automatic logic is_sub(mdu_op_t op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// Request/result bundle between the execute stage (master) and the MDU (slave).
interface hilo_mdu_if #(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] hi_wdata;
   logic [WIDTH-1:0] lo_wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, cancel, hi_we, lo_we, hi_wdata, lo_wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, cancel, hi_we, lo_we, hi_wdata, lo_wdata,
      output busy, done, div_by_zero, hi, lo
   );

endinterface

// File: rtl/mdu_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on unsigned
// magnitudes, sharing one 2*WIDTH accumulator ({remainder, quotient} when dividing).
module mdu_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init,
   input  logic               step,
   input  logic               mode_div,
   input  logic [WIDTH-1:0]   opa,
   input  logic [WIDTH-1:0]   opb,
   output logic [2*WIDTH-1:0] prod,
   output logic [WIDTH-1:0]   quot,
   output logic [WIDTH-1:0]   rem,
   output logic               last
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opd_q;
   logic               mode_q;
   logic [CW-1:0]      cnt_q;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opd_q} : '0);
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opd_q};
      // The partial remainder stays below the divisor, so the difference fits WIDTH bits.
      div_diff  = div_shift[WIDTH-1:0] - opd_q;
      acc_d     = acc_q;
      if (mode_q) begin
         if (div_ge) acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
         else        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q  <= '0;
         opd_q  <= '0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
      end else if (init) begin
         acc_q  <= {{WIDTH{1'b0}}, (mode_div ? opa : opb)};
         opd_q  <= mode_div ? opb : opa;
         mode_q <= mode_div;
         cnt_q  <= '0;
      end else if (step) begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_q + CW'(1);
      end
   end

   assign last = (cnt_q == CW'(WIDTH - 1));
   assign prod = acc_q;
   assign quot = acc_q[WIDTH-1:0];
   assign rem  = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO, MADD/MSUB accumulation,
// flush cancellation and a busy/done handshake for execute-stage stalling.
module hilo_mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit ACCUM_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   hilo_mdu_if.slave  bus
);

   mdu_state_t       state_q, state_d;
   mdu_op_t          op_q;
   mdu_op_t          op_in;
   logic             neg_q, rneg_q, zdiv_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             busy_q, done_q, dbz_q;
   logic             done_d, dbz_d, res_we;

   logic             a_neg, b_neg, accept;
   logic [WIDTH-1:0] a_mag, b_mag;

   logic [2*WIDTH-1:0] prod, prod_s, mul_res, res;
   logic [WIDTH-1:0]   quot, rem, quot_s, rem_s;
   logic               last;

   assign op_in  = mdu_op_t'(bus.op);
   assign a_neg  = is_signed(op_in) & bus.a[WIDTH-1];
   assign b_neg  = is_signed(op_in) & bus.b[WIDTH-1];
   assign a_mag  = a_neg ? -bus.a : bus.a;
   assign b_mag  = b_neg ? -bus.b : bus.b;
   assign accept = (state_q == ST_IDLE) & bus.start & ~bus.cancel;

   mdu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rst      (rst),
      .init     (accept),
      .step     (state_q == ST_RUN),
      .mode_div (is_div(op_in)),
      .opa      (a_mag),
      .opb      (b_mag),
      .prod     (prod),
      .quot     (quot),
      .rem      (rem),
      .last     (last)
   );

   // Sign correction and accumulation against the HI/LO value held during FINISH.
   always_comb begin
      prod_s  = neg_q ? -prod : prod;
      quot_s  = neg_q ? -quot : quot;
      rem_s   = rneg_q ? -rem : rem;
      mul_res = prod_s;
      if (ACCUM_EN && is_accum(op_q)) begin
         if (is_sub(op_q)) mul_res = {hi_q, lo_q} - prod_s;
         else              mul_res = {hi_q, lo_q} + prod_s;
      end
      res = is_div(op_q) ? {rem_s, quot_s} : mul_res;
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      res_we  = 1'b0;
      unique case (state_q)
         ST_IDLE:   if (accept) state_d = ST_RUN;
         ST_RUN:    if (last) state_d = ST_FINISH;
         ST_FINISH: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            dbz_d   = is_div(op_q) & zdiv_q;
            res_we  = ~(is_div(op_q) & zdiv_q);
         end
         default:   state_d = ST_IDLE;
      endcase
      if (bus.cancel) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
         dbz_d   = 1'b0;
         res_we  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_MULT;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         zdiv_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         if (accept) begin
            op_q   <= op_in;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            zdiv_q <= (bus.b == '0);
         end
         if (res_we) begin
            {hi_q, lo_q} <= res;
         end else if (state_q == ST_IDLE) begin
            if (bus.hi_we) hi_q <= bus.hi_wdata;
            if (bus.lo_we) lo_q <= bus.lo_wdata;
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;

endmodule
